// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-requester arbiter in front of a single-port memory.
// m0 (core) and m1 (loader/debug) share one port; a locked grant keeps ownership.
// Optional build macro MEM_ARB_ROUND_ROBIN_EN: IDLE ties go to the requester not
// granted most recently; when undefined, m0 always wins IDLE ties.
module mem_port_arbiter #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            m0_req_i,
  input  logic            m1_req_i,
  input  logic            m0_we_i,
  input  logic            m1_we_i,
  input  logic            m0_lock_i,
  input  logic            m1_lock_i,
  input  logic [XLEN-1:0] m0_addr_i,
  input  logic [XLEN-1:0] m1_addr_i,
  input  logic [XLEN-1:0] m0_wdata_i,
  input  logic [XLEN-1:0] m1_wdata_i,
  output logic            m0_gnt_o,
  output logic            m1_gnt_o,
  output logic            m0_rvalid_o,
  output logic            m1_rvalid_o,
  output logic [XLEN-1:0] rdata_o,
  output logic            mem_we_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN-1:0] mem_wd_o,
  input  logic [XLEN-1:0] mem_rd_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic            w_gnt0;
  logic            w_gnt1;
  logic            w_prefer1;
  logic            w_rd_gnt0;
  logic            w_rd_gnt1;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_wdata;
  logic [XLEN-1:0] r_rdata;
  logic            r_rvalid0;
  logic            r_rvalid1;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic r_rr_prefer1;

  // Round-robin pointer: whoever was just granted loses the next IDLE tie
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_rr_prefer1 <= 1'b0;
    end else if (w_gnt0) begin
      r_rr_prefer1 <= 1'b1;
    end else if (w_gnt1) begin
      r_rr_prefer1 <= 1'b0;
    end
  end

  assign w_prefer1 = r_rr_prefer1;
`else
  assign w_prefer1 = 1'b0;
`endif

  // Ownership state register
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next ownership: take it on a locked grant, give it up on an unlocked grant or dropped request
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_gnt0 && m0_lock_i) begin
          w_next_state = OWN0;
        end else if (w_gnt1 && m1_lock_i) begin
          w_next_state = OWN1;
        end
      end
      OWN0: begin
        if (!m0_req_i || !m0_lock_i) begin
          w_next_state = IDLE;
        end
      end
      OWN1: begin
        if (!m1_req_i || !m1_lock_i) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Grant decode: same-cycle grant from requests and ownership, silenced while in reset
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    case (r_state)
      IDLE: begin
        if (m0_req_i && m1_req_i) begin
          w_gnt0 = !w_prefer1;
          w_gnt1 = w_prefer1;
        end else begin
          w_gnt0 = m0_req_i;
          w_gnt1 = m1_req_i;
        end
      end
      OWN0:    w_gnt0 = m0_req_i;
      OWN1:    w_gnt1 = m1_req_i;
      default: ;
    endcase
    if (!rstn_i) begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
    end
  end

  assign w_rd_gnt0 = w_gnt0 && !m0_we_i;
  assign w_rd_gnt1 = w_gnt1 && !m1_we_i;

  // Remember the last granted address/data so the memory bus holds steady when idle
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_gnt0) begin
      r_addr  <= m0_addr_i;
      r_wdata <= m0_wdata_i;
    end else if (w_gnt1) begin
      r_addr  <= m1_addr_i;
      r_wdata <= m1_wdata_i;
    end
  end

  // Read return: capture memory data on a read grant and flag the owner one cycle later
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_rdata   <= '0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
    end else begin
      r_rvalid0 <= w_rd_gnt0;
      r_rvalid1 <= w_rd_gnt1;
      if (w_rd_gnt0 || w_rd_gnt1) begin
        r_rdata <= mem_rd_i;
      end
    end
  end

  assign m0_gnt_o    = w_gnt0;
  assign m1_gnt_o    = w_gnt1;
  assign m0_rvalid_o = r_rvalid0;
  assign m1_rvalid_o = r_rvalid1;
  assign rdata_o     = r_rdata;
  assign mem_we_o    = (w_gnt0 && m0_we_i) || (w_gnt1 && m1_we_i);
  assign mem_addr_o  = w_gnt0 ? m0_addr_i  : (w_gnt1 ? m1_addr_i  : r_addr);
  assign mem_wd_o    = w_gnt0 ? m0_wdata_i : (w_gnt1 ? m1_wdata_i : r_wdata);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter.
// Stimulus predicts grants and read data from the arbitration rules and a
// reference memory; a monitor on the falling edge compares what the DUT shows.
module tb_mem_port_arbiter;

  localparam int XLEN = 32;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic            clk_i = 1'b0;
  logic            rstn_i;
  logic            m0_req_i, m1_req_i, m0_we_i, m1_we_i, m0_lock_i, m1_lock_i;
  logic [XLEN-1:0] m0_addr_i, m1_addr_i, m0_wdata_i, m1_wdata_i;
  logic            m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o;
  logic [XLEN-1:0] rdata_o;
  logic            mem_we_o;
  logic [XLEN-1:0] mem_addr_o, mem_wd_o, mem_rd_i;

  mem_port_arbiter #(.XLEN(XLEN)) dut (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .m0_req_i   (m0_req_i),
    .m1_req_i   (m1_req_i),
    .m0_we_i    (m0_we_i),
    .m1_we_i    (m1_we_i),
    .m0_lock_i  (m0_lock_i),
    .m1_lock_i  (m1_lock_i),
    .m0_addr_i  (m0_addr_i),
    .m1_addr_i  (m1_addr_i),
    .m0_wdata_i (m0_wdata_i),
    .m1_wdata_i (m1_wdata_i),
    .m0_gnt_o   (m0_gnt_o),
    .m1_gnt_o   (m1_gnt_o),
    .m0_rvalid_o(m0_rvalid_o),
    .m1_rvalid_o(m1_rvalid_o),
    .rdata_o    (rdata_o),
    .mem_we_o   (mem_we_o),
    .mem_addr_o (mem_addr_o),
    .mem_wd_o   (mem_wd_o),
    .mem_rd_i   (mem_rd_i)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit monActive = 1'b0;

  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic logic [31:0] patWord(input int idx);
    if (idx == 4) return 32'hDEADBEEF;
    return 32'h1000_0000 + 32'(idx) * 32'h0001_0101;
  endfunction

  // Physical memory seen by the DUT: combinational read, write on the clock edge
  logic [31:0] memArr [256];
  assign mem_rd_i = memArr[mem_addr_o[9:2]];

  initial begin
    for (int i = 0; i < 256; i++) memArr[i] <= patWord(i);
    forever begin
      @(posedge clk_i);
      if (mem_we_o) memArr[mem_addr_o[9:2]] <= mem_wd_o;
    end
  end

  // Reference model state: owner (-1 none), last winner, and memory contents
  int          owner   = -1;
  int          lastWin = 1;
  logic [31:0] refMem [int];

  typedef struct {
    int          port;
    logic [31:0] data;
    int          cyc;
  } rd_t;

  rd_t        rdQ[$];
  logic [1:0] gntQ[$];

  function automatic logic [31:0] refRead(input logic [31:0] a);
    int w = int'(a >> 2);
    if (refMem.exists(w)) return refMem[w];
    return patWord(w);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one cycle of requests and push the outcome the arbitration rules predict
  task automatic applyStimulus(input bit r0, input bit w0, input bit l0,
                               input logic [31:0] a0, input logic [31:0] d0,
                               input bit r1, input bit w1, input bit l1,
                               input logic [31:0] a1, input logic [31:0] d1,
                               output int win);
    rd_t e;
    bit  we, lk;
    logic [31:0] a, d;
    @(posedge clk_i);
    #1;
    m0_req_i = r0; m0_we_i = w0; m0_lock_i = l0; m0_addr_i = a0; m0_wdata_i = d0;
    m1_req_i = r1; m1_we_i = w1; m1_lock_i = l1; m1_addr_i = a1; m1_wdata_i = d1;
    win = -1;
    if (owner >= 0) begin
      if ((owner == 0) ? r0 : r1) win = owner;
    end else if (r0 && r1) begin
      win = (RR && lastWin == 0) ? 1 : 0;
    end else if (r0) begin
      win = 0;
    end else if (r1) begin
      win = 1;
    end
    if (win < 0) begin
      owner = -1;
    end else begin
      lastWin = win;
      we = (win == 0) ? w0 : w1;
      lk = (win == 0) ? l0 : l1;
      a  = (win == 0) ? a0 : a1;
      d  = (win == 0) ? d0 : d1;
      owner = lk ? win : -1;
      if (we) begin
        refMem[int'(a >> 2)] = d;
      end else begin
        e.port = win;
        e.data = refRead(a);
        e.cyc  = cyc;
        rdQ.push_back(e);
      end
    end
    gntQ.push_back({win == 1, win == 0});
  endtask

  task automatic idleCycle();
    int w;
    applyStimulus(0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0, w);
  endtask

  // Monitor: compare grants every cycle and read returns whenever one is due or shown
  logic [1:0] expGnt;
  rd_t        expRd;
  bit         haveRd;

  initial begin
    forever begin
      @(negedge clk_i);
      if (monActive) begin
        if (gntQ.size() > 0) begin
          expGnt = gntQ.pop_front();
          checkOutput("grant", {30'b0, m1_gnt_o, m0_gnt_o}, {30'b0, expGnt});
        end
        haveRd = 1'b0;
        if (rdQ.size() > 0 && rdQ[0].cyc == cyc - 1) begin
          expRd  = rdQ.pop_front();
          haveRd = 1'b1;
        end
        if (haveRd || m0_rvalid_o || m1_rvalid_o) begin
          checkOutput("rvalid", {30'b0, m1_rvalid_o, m0_rvalid_o},
                      {30'b0, haveRd && expRd.port == 1, haveRd && expRd.port == 0});
          if (haveRd) checkOutput("rdata", rdata_o, expRd.data);
        end
      end
    end
  end

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_gnt0"},   {31'b0, m0_gnt_o},    32'h0);
    checkOutput({tag, "_gnt1"},   {31'b0, m1_gnt_o},    32'h0);
    checkOutput({tag, "_rv0"},    {31'b0, m0_rvalid_o}, 32'h0);
    checkOutput({tag, "_rv1"},    {31'b0, m1_rvalid_o}, 32'h0);
    checkOutput({tag, "_we"},     {31'b0, mem_we_o},    32'h0);
    checkOutput({tag, "_addr"},   mem_addr_o,           32'h0);
    checkOutput({tag, "_wd"},     mem_wd_o,             32'h0);
    checkOutput({tag, "_rdata"},  rdata_o,              32'h0);
  endtask

  bit          pend[2];
  bit          pw[2];
  bit          pl[2];
  logic [31:0] pa[2];
  logic [31:0] pd[2];

  initial begin
    int w;
    rstn_i   = 1'b0;
    m0_req_i = 1'b1; m0_we_i = 1'b0; m0_lock_i = 1'b1; m0_addr_i = 32'h10; m0_wdata_i = '0;
    m1_req_i = 1'b0; m1_we_i = 1'b0; m1_lock_i = 1'b0; m1_addr_i = '0;    m1_wdata_i = '0;
    #12;
    checkAllZero("reset");
    m0_req_i = 1'b0; m0_lock_i = 1'b0;
    @(negedge clk_i);
    rstn_i    = 1'b1;
    monActive = 1'b1;

    // Both writing every cycle, no lock
    for (int k = 0; k < 4; k++)
      applyStimulus(1, 1, 0, 32'h40, 32'hA0A0A0A0, 1, 1, 0, 32'h44, 32'hB1B1B1B1, w);
    idleCycle();

    // m0 read of the preloaded word at 0x10
    applyStimulus(1, 0, 0, 32'h10, 32'h0, 0, 0, 0, 32'h0, 32'h0, w);
    idleCycle();
    idleCycle();

    // m1 takes a lock, m0 waits until m1 releases it
    applyStimulus(0, 0, 0, 32'h0, 32'h0, 1, 1, 1, 32'h80, 32'h11110000, w);
    for (int k = 0; k < 3; k++)
      applyStimulus(1, 0, 0, 32'h10, 32'h0, 1, 1, 1, 32'h84 + 32'(k) * 4, 32'h22220000 + 32'(k), w);
    applyStimulus(1, 0, 0, 32'h10, 32'h0, 1, 1, 0, 32'h90, 32'h33330000, w);
    applyStimulus(1, 0, 0, 32'h10, 32'h0, 0, 0, 0, 32'h0, 32'h0, w);
    idleCycle();
    idleCycle();

    // Write by m0 followed immediately by a read of the same word by m1
    applyStimulus(1, 1, 0, 32'h20, 32'h12345678, 0, 0, 0, 32'h0, 32'h0, w);
    applyStimulus(0, 0, 0, 32'h0, 32'h0, 1, 0, 0, 32'h20, 32'h0, w);
    idleCycle();
    idleCycle();

    // Reset pulse in the grant cycle of a locked read
    @(posedge clk_i);
    #1;
    monActive = 1'b0;
    m0_req_i = 1'b1; m0_we_i = 1'b0; m0_lock_i = 1'b1; m0_addr_i = 32'h10;
    #2;
    checkOutput("pre_rst_gnt0", {31'b0, m0_gnt_o}, 32'h1);
    checkOutput("pre_rst_addr", mem_addr_o, 32'h10);
    rstn_i = 1'b0;
    #1;
    checkAllZero("midrst");
    m0_req_i = 1'b0; m0_lock_i = 1'b0;
    @(posedge clk_i);
    #3;
    rstn_i = 1'b1;
    @(negedge clk_i);
    checkOutput("post_rst_rv", {30'b0, m1_rvalid_o, m0_rvalid_o}, 32'h0);
    @(posedge clk_i);
    #1;
    m1_req_i = 1'b1; m1_we_i = 1'b0; m1_lock_i = 1'b0; m1_addr_i = 32'h10;
    #4;
    checkOutput("post_rst_idle", {30'b0, m1_gnt_o, m0_gnt_o}, 32'h2);
    @(posedge clk_i);
    #1;
    m1_req_i = 1'b0;
    @(negedge clk_i);
    checkOutput("post_rst_rv1", {30'b0, m1_rvalid_o, m0_rvalid_o}, 32'h2);
    checkOutput("post_rst_rdata", rdata_o, refRead(32'h10));
    owner     = -1;
    lastWin   = 1;
    monActive = 1'b1;

    // Random two-requester stress against the reference memory
    for (int p = 0; p < 2; p++) pend[p] = 1'b0;
    for (int k = 0; k < 10000; k++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && $urandom_range(0, 99) < 60) begin
          pend[p] = 1'b1;
          pw[p]   = 1'($urandom_range(0, 1));
          pl[p]   = ($urandom_range(0, 3) == 0);
          pa[p]   = 32'($urandom_range(0, 15)) * 4;
          pd[p]   = $urandom;
        end
      end
      applyStimulus(pend[0], pw[0], pend[0] && pl[0], pa[0], pd[0],
                    pend[1], pw[1], pend[1] && pl[1], pa[1], pd[1], w);
      if (w == 0) pend[0] = 1'b0;
      if (w == 1) pend[1] = 1'b0;
    end
    idleCycle();
    idleCycle();
    idleCycle();
    @(posedge clk_i);
    #1;
    checkOutput("drain_rd",  32'(rdQ.size()),  32'h0);
    checkOutput("drain_gnt", 32'(gntQ.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, data and address width.
REQ-002 SHALL have port clk_i  input  1  system clock, all state on the rising edge.
REQ-003 SHALL have port rstn_i  input  1  system reset, asynchronous, active-low.
REQ-004 SHALL have port m0_req_i / m1_req_i  input  1  request from core (m0) or loader/debug (m1).
REQ-005 SHALL have port m0_we_i / m1_we_i  input  1  request is a write.
REQ-006 SHALL have port m0_lock_i / m1_lock_i  input  1  keep ownership after this access.
REQ-007 SHALL have port m0_addr_i / m1_addr_i  input  XLEN  byte address.
REQ-008 SHALL have port m0_wdata_i / m1_wdata_i  input  XLEN  write data.
REQ-009 SHALL have port m0_gnt_o / m1_gnt_o  output  1  access accepted this cycle.
REQ-010 SHALL have port m0_rvalid_o / m1_rvalid_o  output  1  read data valid, one cycle after a read grant.
REQ-011 SHALL have port rdata_o  output  XLEN  registered read data, shared by both requesters.
REQ-012 SHALL have port mem_we_o  output  1  memory write enable.
REQ-013 SHALL have port mem_addr_o  output  XLEN  memory address.
REQ-014 SHALL have port mem_wd_o  output  XLEN  memory write data.
REQ-015 SHALL have port mem_rd_i  input  XLEN  memory read data, combinational from mem_addr_o.

Function
REQ-016 SHALL have states IDLE, OWN0 and OWN1, with at most one grant per cycle and never both gnt outputs high together.
REQ-017 In IDLE, when only one requester is requesting, that requester SHALL be granted in the same cycle (gnt is combinational from req and state).
REQ-018 In IDLE with both requesting, the winner SHALL be chosen per REQ-029/REQ-030.
REQ-019 A grant with lock_i=1 SHALL move the FSM to OWNx; a grant with lock_i=0, or no grant, SHALL leave the FSM in IDLE.
REQ-020 In OWNx, only requester x SHALL be grantable; the other requester waits regardless of its req.
REQ-021 The FSM SHALL return from OWNx to IDLE when requester x is granted with lock_i=0, or when it drops req_i.
REQ-022 In the grant cycle, mem_addr_o, mem_wd_o and mem_we_o SHALL mux from the granted requester; with no grant, mem_we_o=0 and the address/data SHALL hold their last values.
REQ-023 Read path:
- on a read grant, mem_rd_i SHALL be captured into rdata_o at the clock edge;
- the matching rvalid_o SHALL pulse high for exactly one cycle, in the cycle after the grant.
REQ-024 A write grant SHALL produce no rvalid pulse.
REQ-025 Back-to-back grants SHALL be allowed every cycle, giving a throughput of one access per cycle.
REQ-026 A requester SHALL hold req, we, addr and wdata stable until its gnt is seen; this is a requester obligation, and the arbiter does not check it.

Reset
REQ-027 While rstn_i=0, the block SHALL asynchronously force:
- FSM to IDLE;
- rdata_o=0, both rvalid_o=0, mem_we_o=0, mem_addr_o=0, mem_wd_o=0;
- the round-robin pointer to m0 preferred.
REQ-028 Reset asserted mid-access SHALL drop that access, and no rvalid SHALL follow after reset release.

Configuration
REQ-029 With macro MEM_ARB_ROUND_ROBIN_EN defined:
- IDLE ties SHALL go to the requester not granted most recently;
- the pointer SHALL update on every grant.
REQ-030 With MEM_ARB_ROUND_ROBIN_EN undefined, IDLE ties SHALL always go to m0 (fixed priority), and no pointer register SHALL exist.

Verification
REQ-031 Bench SHALL cover: m0 read of addr 0x10 where memory holds 0xDEADBEEF -> m0_gnt_o=1 in cycle N, m0_rvalid_o=1 with rdata_o=0xDEADBEEF in cycle N+1, m1_rvalid_o=0.
REQ-032 Bench SHALL cover: both requesting writes every cycle, lock=0, for 4 cycles -> with RR defined, grants alternate m0,m1,m0,m1; without RR, grants go m0,m0,m0,m0.
REQ-033 Bench SHALL cover: m1 granted with lock=1, then m0 requests for 3 cycles while m1 keeps issuing -> m0_gnt_o stays 0 until m1 is granted with lock=0, after which m0 is granted the next cycle.
REQ-034 Bench SHALL cover: m0 write of 0x12345678 to 0x20, then m1 read of 0x20 the next cycle -> rdata_o=0x12345678 with m1_rvalid_o=1.
REQ-035 Bench SHALL cover: rstn_i pulsed low in the grant cycle of a read -> all outputs go 0 immediately, no rvalid after release, FSM in IDLE.
REQ-036 Bench SHALL cover: a random two-requester stress of 10k cycles against a reference memory model -> no dual grant, and every read returns the last written data.
